nibble_serial_sub: RTL and testbench
====================================

Name: nibble_serial_sub

Overview:
- Multi-cycle subtractor that computes D = A - B - BI four bits per clock, least-significant nibble first.
- A registered borrow links successive nibbles.
- It is the subtract-direction counterpart of the 4-bit carry-lookahead adder macro.
- It serves blitter/DSP-side address and count arithmetic where a full-width subtract path is too costly and a few cycles of latency are acceptable.
- Start/done handshake with a registered result, borrow-out and zero flag.

Parameters:
- NIB, 4, number of 4-bit nibbles; operand width is 4*NIB (default 16).

Ports:
- CLK  in  1  system clock, rising edge
- RESETL  in  1  asynchronous active-low reset
- START  in  1  request; sampled only while idle (BUSY=0)
- A  in  4*NIB  minuend, captured on the accepting edge
- B  in  4*NIB  subtrahend, captured on the accepting edge
- BI  in  1  borrow in, captured on the accepting edge
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle pulse: D/BO/Z freshly updated
- D  out  4*NIB  difference, held until the next completion
- BO  out  1  borrow out of the top nibble (1 = A < B+BI, unsigned)
- Z  out  1  1 when D == 0

Behaviour:
- One clock domain; RESETL is asynchronous assert, synchronous deassert at the system level.
- While RESETL=0, all state is cleared: state=IDLE, BUSY=0, DONE=0, D=0, BO=0, Z=0, nibble counter=0, operand and borrow registers=0.
- States:
  - IDLE: waiting for START.
  - RUN: counter k = 0..NIB-1.
  - FIN: one cycle, DONE=1.
- IDLE -> RUN: on a rising edge with START=1.
  - Captures A, B and BI into shift registers; sets the borrow register to BI and k=0.
  - BUSY=1 from that edge.
- RUN, each edge:
  - Nibble k: {borrow', diff} = A_nib - B_nib - borrow, computed as A_nib + ~B_nib + ~borrow with borrow' = ~carry.
  - diff shifts into the result register MSB-first, so nibble 0 ends in bits [3:0].
  - The operand registers shift right by 4; k increments.
- RUN -> FIN: on the edge processing k = NIB-1.
  - On that same edge: D <= full result, BO <= final borrow, Z <= (result == 0).
  - Also on that edge: BUSY <= 0, DONE <= 1.
- FIN -> IDLE: next edge; DONE <= 0.
  - START=1 on this edge is accepted (FIN counts as idle), giving back-to-back ops every NIB+1 cycles.
- Latency: START sampled at edge N; DONE high between edges N+NIB and N+NIB+1.
- START while BUSY=1 is ignored; it is neither queued nor able to corrupt the operands.
- A/B/BI may change freely after the accepting edge.
- D, BO and Z change only at completion; intermediate nibbles are never visible on D.
- Reset mid-operation aborts at once. No DONE is produced and the outputs return to their reset values.
- Wrap-around: the result is modulo 2^(4*NIB); BO flags the underflow.
- NIB=1 is legal: RUN lasts one edge.

Decomposition:
- Shared package konix_arith_pkg:
  - NIB_W=4.
  - Enum sub_state_t {IDLE, RUN, FIN}.
  - Function for the counter width, $clog2(NIB) min 1.
- Sub-module sub4_slice: combinational 4-bit subtract with borrow.
  - Inputs A[3:0], B[3:0], BI; outputs D[3:0], BO.
  - Borrow-lookahead structure mirroring the adder macro.
  - Instantiated once and reused each cycle.

Test Plan:
- Reset, then A=0x1234, B=0x0234, BI=0, START pulse -> after 4 cycles DONE=1 for one cycle, D=0x1000, BO=0, Z=0; BUSY high exactly 4 cycles.
- A=0x0000, B=0x0001, BI=0 -> D=0xFFFF, BO=1, Z=0; then A=0x1000, B=0x0001 -> D=0x0FFF, BO=0 (borrow ripples through three nibbles).
- A=0x5A5A, B=0x5A5A, BI=0 -> D=0x0000, Z=1, BO=0; then A=0x8000, B=0x0000, BI=1 -> D=0x7FFF, Z=0, BO=0.
- START held high continuously with operands changing every cycle -> ops accepted every 5 cycles; each D matches the operands present on its accepting edge; intervening STARTs ignored.
- RESETL pulled low during RUN at k=2 -> BUSY/DONE/D/BO/Z all 0 immediately (asynchronous); no DONE afterwards; the next op after release is correct.
- NIB=1 build: A=0x3, B=0x5, BI=0 -> DONE one cycle after acceptance, D=0xE, BO=1.

Source files
------------

// File: rtl/konix_arith_pkg.sv
// konix_arith_pkg
// Shared definitions for the nibble-serial arithmetic blocks.
//   NIB_W       : width of one processing slice (bits)
//   sub_state_t : control states of the serial subtractor
//   cnt_w()     : width of the nibble counter, never narrower than 1 bit
package konix_arith_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } sub_state_t;

  function automatic int cnt_w(input int nib);
    return (nib < 2) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/nibble_serial_sub_if.sv
// nibble_serial_sub_if
// Start/done handshake and operand/result bus of the serial subtractor.
//   START, A, B, BI : request and operands (master -> slave)
//   BUSY, DONE      : operation in progress / one-cycle completion pulse
//   D, BO, Z        : registered difference, borrow out, zero flag
interface nibble_serial_sub_if
  import konix_arith_pkg::*;
#(
  parameter int NIB = 4
);

  localparam int DATA_W = NIB_W * NIB;

  logic              START;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              BI;
  logic              BUSY;
  logic              DONE;
  logic [DATA_W-1:0] D;
  logic              BO;
  logic              Z;

  modport master (
    output START, A, B, BI,
    input  BUSY, DONE, D, BO, Z
  );

  modport slave (
    input  START, A, B, BI,
    output BUSY, DONE, D, BO, Z
  );

endinterface

// File: rtl/sub4_slice.sv
// sub4_slice
// Combinational 4-bit subtract with borrow: {BO, D} = A - B - BI.
// Borrow-lookahead form, the mirror image of the 4-bit carry-lookahead adder:
//   generate  g[i] = ~A[i] & B[i]   (bit borrows regardless of incoming borrow)
//   propagate p[i] = ~(A[i] ^ B[i]) (bit passes an incoming borrow through)
//   A, B : nibble operands     BI : borrow in
//   D    : difference nibble   BO : borrow out
module sub4_slice
  import konix_arith_pkg::*;
(
  input  logic [NIB_W-1:0] A,
  input  logic [NIB_W-1:0] B,
  input  logic             BI,
  output logic [NIB_W-1:0] D,
  output logic             BO
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W:0]   bw;

  assign g = ~A & B;
  assign p = ~(A ^ B);

  // All borrows computed in parallel from BI rather than rippling.
  assign bw[0] = BI;
  assign bw[1] = g[0] | (p[0] & BI);
  assign bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & BI);
  assign bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & BI);
  assign bw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & BI);

  assign D  = A ^ B ^ bw[NIB_W-1:0];
  assign BO = bw[NIB_W];

endmodule

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub
// Multi-cycle subtractor D = A - B - BI, one nibble per clock, LS nibble first.
//   CLK    : system clock, rising edge
//   RESETL : asynchronous active-low reset
//   bus    : slave side of nibble_serial_sub_if (START/A/B/BI in,
//            BUSY/DONE/D/BO/Z out)
// START is accepted in IDLE or FIN; the operation takes NIB RUN edges,
// then DONE pulses for one cycle with D/BO/Z updated on the same edge.
module nibble_serial_sub
  import konix_arith_pkg::*;
#(
  parameter int NIB = 4
) (
  input  logic                CLK,
  input  logic                RESETL,
  nibble_serial_sub_if.slave  bus
);

  localparam int DATA_W = NIB_W * NIB;
  localparam int CNT_W  = cnt_w(NIB);

  sub_state_t        state_q,  state_d;
  logic [CNT_W-1:0]  k_q,      k_d;
  logic [DATA_W-1:0] a_q,      a_d;
  logic [DATA_W-1:0] b_q,      b_d;
  logic              borrow_q, borrow_d;
  logic [DATA_W-1:0] res_q,    res_d;
  logic [DATA_W-1:0] d_q,      d_d;
  logic              bo_q,     bo_d;
  logic              z_q,      z_d;

  logic [NIB_W-1:0]  slice_d;
  logic              slice_bo;
  logic [DATA_W-1:0] res_shift;

  // The single slice always works on the low nibble of the shifting operands.
  sub4_slice u_slice (
    .A  (a_q[NIB_W-1:0]),
    .B  (b_q[NIB_W-1:0]),
    .BI (borrow_q),
    .D  (slice_d),
    .BO (slice_bo)
  );

  // New nibble enters at the top, so after NIB shifts nibble 0 sits in [3:0].
  generate
    if (NIB == 1) begin : g_single
      assign res_shift = slice_d;
    end else begin : g_multi
      assign res_shift = {slice_d, res_q[DATA_W-1:NIB_W]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    res_d    = res_q;
    d_d      = d_q;
    bo_d     = bo_q;
    z_d      = z_q;
    unique case (state_q)
      IDLE, FIN: begin
        // FIN behaves as idle so ops can be issued back to back.
        state_d = IDLE;
        if (bus.START) begin
          state_d  = RUN;
          a_d      = bus.A;
          b_d      = bus.B;
          borrow_d = bus.BI;
          k_d      = '0;
        end
      end
      RUN: begin
        a_d      = a_q >> NIB_W;
        b_d      = b_q >> NIB_W;
        borrow_d = slice_bo;
        res_d    = res_shift;
        k_d      = k_q + CNT_W'(1);
        if (k_q == CNT_W'(NIB - 1)) begin
          state_d = FIN;
          k_d     = '0;
          d_d     = res_shift;
          bo_d    = slice_bo;
          z_d     = (res_shift == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      res_q    <= '0;
      d_q      <= '0;
      bo_q     <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      res_q    <= res_d;
      d_q      <= d_d;
      bo_q     <= bo_d;
      z_q      <= z_d;
    end
  end

  assign bus.BUSY = (state_q == RUN);
  assign bus.DONE = (state_q == FIN);
  assign bus.D    = d_q;
  assign bus.BO   = bo_q;
  assign bus.Z    = z_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// tb_nibble_serial_sub
// Bench for nibble_serial_sub: a 16-bit instance checked every cycle against
// an arithmetic model (result = A - B - BI taken on the accepting edge,
// delivered NIB cycles later), plus directed literal cases, and a NIB=1
// instance checked with directed and random operations.
module tb_nibble_serial_sub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nibble_serial_sub_if #(.NIB(4)) bus0 ();
  nibble_serial_sub_if #(.NIB(1)) bus1 ();

  nibble_serial_sub #(.NIB(4)) dut0 (.CLK(clk), .RESETL(rst_n), .bus(bus0));
  nibble_serial_sub #(.NIB(1)) dut1 (.CLK(clk), .RESETL(rst_n), .bus(bus1));

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Behavioural model of the 16-bit instance: a busy countdown and the
  // arithmetic result computed in one go at acceptance.
  logic        m_busy, m_done, m_bo, m_z;
  logic [15:0] m_d;
  logic [16:0] m_pend;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_bo <= 1'b0; m_z <= 1'b0;
      m_d <= '0; m_pend <= '0; m_cnt <= 0;
    end else if (!m_busy && bus0.START) begin
      m_busy <= 1'b1;
      m_done <= 1'b0;
      m_cnt  <= 4;
      m_pend <= {1'b0, bus0.A} - {1'b0, bus0.B} - 17'(bus0.BI);
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_d    <= m_pend[15:0];
        m_bo   <= m_pend[16];
        m_z    <= (m_pend[15:0] == 16'h0);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(bus0.BUSY), 32'(m_busy));
      chk("done", 32'(bus0.DONE), 32'(m_done));
      chk("d",    32'(bus0.D),    32'(m_d));
      chk("bo",   32'(bus0.BO),   32'(m_bo));
      chk("z",    32'(bus0.Z),    32'(m_z));
    end
  end

  // Directed op on the 16-bit instance; entered and left at posedge+2.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic bi, input logic [15:0] exp_d, input logic exp_bo,
                        input logic exp_z);
    int busy_cnt = 0;
    bit seen = 1'b0;
    bus0.START = 1'b1; bus0.A = a; bus0.B = b; bus0.BI = bi;
    @(posedge clk); #2;
    bus0.START = 1'b0; bus0.A = 16'($urandom); bus0.B = 16'($urandom); bus0.BI = 1'($urandom);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus0.DONE) seen = 1'b1;
      else if (bus0.BUSY) busy_cnt++;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
    chk({name, "_d"}, 32'(bus0.D), 32'(exp_d));
    chk({name, "_bo"}, 32'(bus0.BO), 32'(exp_bo));
    chk({name, "_z"}, 32'(bus0.Z), 32'(exp_z));
    @(negedge clk);
    chk({name, "_done_one_cycle"}, 32'(bus0.DONE), 32'd0);
    @(posedge clk); #2;
  endtask

  initial begin
    int          dones;
    logic [3:0]  a1, b1;
    logic        bi1;
    logic [4:0]  e1;
    rst_n = 1'b0;
    bus0.START = 1'b0; bus0.A = '0; bus0.B = '0; bus0.BI = 1'b0;
    bus1.START = 1'b0; bus1.A = '0; bus1.B = '0; bus1.BI = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus0.BUSY), 32'd0);
    chk("rst_done", 32'(bus0.DONE), 32'd0);
    chk("rst_d", 32'(bus0.D), 32'd0);
    chk("rst_bo_z", 32'({bus0.BO, bus0.Z}), 32'd0);
    @(posedge clk); #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_op("op1234", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op("under",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_op("ripple", 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    run_op("zero",   16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b1);
    run_op("bi8000", 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b0);

    // START held high with operands changing every cycle.
    dones = 0;
    bus0.START = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #2;
      bus0.A = 16'($urandom); bus0.B = 16'($urandom); bus0.BI = 1'($urandom);
      @(negedge clk);
      if (bus0.DONE) dones++;
    end
    @(posedge clk); #2;
    bus0.START = 1'b0;
    chk("b2b_done_count", 32'(dones), 32'd5);
    repeat (8) @(posedge clk);
    #2;

    // Reset in the middle of RUN, after nibbles 0 and 1 have been processed.
    run_op("pre_rst", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    bus0.START = 1'b1; bus0.A = 16'hBEEF; bus0.B = 16'h1111; bus0.BI = 1'b0;
    @(posedge clk); #2;
    bus0.START = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus0.BUSY), 32'd0);
    chk("midrst_done", 32'(bus0.DONE), 32'd0);
    chk("midrst_d", 32'(bus0.D), 32'd0);
    chk("midrst_bo_z", 32'({bus0.BO, bus0.Z}), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus0.DONE) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    @(posedge clk); #2;
    run_op("post_rst", 16'hBEEF, 16'h1111, 1'b1, 16'hADDD, 1'b0, 1'b0);

    // Randomized traffic with occasional extreme operands.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      bus0.START = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: bus0.A = 16'h0000;
        1: bus0.A = 16'hFFFF;
        default: bus0.A = 16'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: bus0.B = 16'h0000;
        1: bus0.B = 16'hFFFF;
        2: bus0.B = bus0.A;
        default: bus0.B = 16'($urandom);
      endcase
      bus0.BI = 1'($urandom);
    end
    bus0.START = 1'b0;
    repeat (8) @(posedge clk);
    #2;

    // NIB=1 instance: DONE one cycle after acceptance.
    bus1.START = 1'b1; bus1.A = 4'h3; bus1.B = 4'h5; bus1.BI = 1'b0;
    @(posedge clk); #2;
    bus1.START = 1'b0;
    @(negedge clk);
    chk("n1_busy", 32'(bus1.BUSY), 32'd1);
    chk("n1_done_early", 32'(bus1.DONE), 32'd0);
    @(posedge clk); #2;
    @(negedge clk);
    chk("n1_done", 32'(bus1.DONE), 32'd1);
    chk("n1_d", 32'(bus1.D), 32'hE);
    chk("n1_bo", 32'(bus1.BO), 32'd1);
    chk("n1_z", 32'(bus1.Z), 32'd0);
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #2;
      a1 = 4'($urandom); b1 = 4'($urandom); bi1 = 1'($urandom);
      e1 = {1'b0, a1} - {1'b0, b1} - 5'(bi1);
      bus1.START = 1'b1; bus1.A = a1; bus1.B = b1; bus1.BI = bi1;
      @(posedge clk); #2;
      bus1.START = 1'b0;
      @(posedge clk); #2;
      @(negedge clk);
      chk("n1r_done", 32'(bus1.DONE), 32'd1);
      chk("n1r_result", 32'({bus1.BO, bus1.D}), 32'(e1));
      chk("n1r_z", 32'(bus1.Z), 32'(e1[3:0] == 4'h0));
    end

    @(posedge clk); #2;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
